// File: rtl/alu_pkg.sv
// Shared definitions for the 3-bit ALU and its operand loader.
// Holds the loader FSM encodings and the datapath widths.
package alu_pkg;

    localparam int unsigned OPND_W = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned RES_W  = 4;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debouncer, registered rising-edge pulse.
// The debouncer is present only when ALU_LOADER_DEBOUNCE_EN is defined.
module alu_btn_conditioner
`ifdef ALU_LOADER_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_prev;
    logic r_pulse;
    logic w_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // Counter only runs while the input disagrees with the accepted level; any agreement restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_prev <= 1'b0;
            r_pulse      <= 1'b0;
        end else begin
            r_level_prev <= w_level;
            r_pulse      <= w_level & ~r_level_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_operand_loader.sv
// ALU input stage: steps the user through entering A, B and the op select via Enter/Clear.
// Define ALU_LOADER_DEBOUNCE_EN to debounce the buttons; otherwise they are used synchronized only.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPND_W-1:0] sw,
    input  logic [SEL_W-1:0]  selSw,
    input  logic              btnEnter,
    input  logic              btnClear,
    output logic [OPND_W-1:0] a,
    output logic [OPND_W-1:0] b,
    output logic [SEL_W-1:0]  swSelect,
    output logic              valid,
    output logic [1:0]        state
);

    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W is too narrow to count DEBOUNCE_CYCLES");
    end

    logic w_enter_p;
    logic w_clear_p;

    alu_btn_conditioner
`ifdef ALU_LOADER_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
`endif
        u_enter_cond (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (btnEnter),
            .o_pulse(w_enter_p)
        );

    alu_btn_conditioner
`ifdef ALU_LOADER_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
`endif
        u_clear_cond (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (btnClear),
            .o_pulse(w_clear_p)
        );

    logic [OPND_W-1:0] r_sw_s1, r_sw_s2;
    logic [SEL_W-1:0]  r_sel_s1, r_sel_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_sel_s1 <= '0;
            r_sel_s2 <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_sel_s1 <= selSw;
            r_sel_s2 <= r_sel_s1;
        end
    end

    state_t            r_state, w_state_next;
    logic [OPND_W-1:0] r_a, w_a_next;
    logic [OPND_W-1:0] r_b, w_b_next;
    logic [SEL_W-1:0]  r_sel, w_sel_next;
    logic              r_valid, w_valid_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_sel   <= w_sel_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_sel_next   = r_sel;
        w_valid_next = r_valid;
        // Clear wins over a coincident Enter.
        if (w_clear_p) begin
            w_state_next = S_A;
            w_a_next     = '0;
            w_b_next     = '0;
            w_sel_next   = '0;
            w_valid_next = 1'b0;
        end else if (w_enter_p) begin
            unique case (r_state)
                S_A: begin
                    w_a_next     = r_sw_s2;
                    w_state_next = S_B;
                end
                S_B: begin
                    w_b_next     = r_sw_s2;
                    w_state_next = S_OP;
                end
                S_OP: begin
                    w_sel_next   = r_sel_s2;
                    w_valid_next = 1'b1;
                    w_state_next = S_DONE;
                end
                S_DONE: begin
                    w_valid_next = 1'b0;
                    w_state_next = S_A;
                end
                default: w_state_next = S_A;
            endcase
        end
    end

    assign a        = r_a;
    assign b        = r_b;
    assign swSelect = r_sel;
    assign valid    = r_valid;
    assign state    = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader: stimulus queues expected output sets,
// a negedge monitor pops one entry for every change it sees on the outputs.
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw;
    logic [1:0] selSw;
    logic       btnEnter;
    logic       btnClear;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] swSelect;
    logic       valid;
    logic [1:0] state;

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .selSw   (selSw),
        .btnEnter(btnEnter),
        .btnClear(btnClear),
        .a       (a),
        .b       (b),
        .swSelect(swSelect),
        .valid   (valid),
        .state   (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Packed output set: {a, b, swSelect, valid, state}
    logic [10:0] exp_q[$];
    string       name_q[$];

    function automatic logic [10:0] pack(input int ea, input int eb, input int es, input int ev,
                                         input int est);
        logic [10:0] v;
        v = {ea[2:0], eb[2:0], es[1:0], ev[0], est[1:0]};
        return v;
    endfunction

    function automatic logic [10:0] cur_out();
        return {a, b, swSelect, valid, state};
    endfunction

    task automatic push(input string nm, input int ea, input int eb, input int es, input int ev,
                        input int est);
        exp_q.push_back(pack(ea, eb, es, ev, est));
        name_q.push_back(nm);
    endtask

    task automatic report(input string nm, input logic [10:0] got, input logic [10:0] want);
        $display("FAIL %s: got a=%0d b=%0d sel=%0d valid=%0d state=%0d, want a=%0d b=%0d sel=%0d valid=%0d state=%0d",
                 nm, got[10:8], got[7:5], got[4:3], got[2], got[1:0],
                 want[10:8], want[7:5], want[4:3], want[2], want[1:0]);
    endtask

    task automatic check_now(input string nm, input logic [10:0] want);
        logic [10:0] got;
        got = cur_out();
        total++;
        if (got !== want) begin
            bad++;
            report(nm, got, want);
        end
    endtask

    // Monitor: every output change outside reset must match the next queued expectation.
    initial begin
        logic [10:0] prev;
        logic [10:0] cur;
        logic [10:0] e;
        string       nm;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = cur_out();
            if (rst !== 1'b0) begin
                prev = cur;
            end else if (cur !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got %h, want no change from %h", cur, prev);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (cur !== e) begin
                        bad++;
                        report(nm, cur, e);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic ent, input logic clr, input int hold);
        btnEnter = ent;
        btnClear = clr;
        cycles(hold);
        btnEnter = 1'b0;
        btnClear = 1'b0;
        cycles(14);
    endtask

    task automatic drain(input string nm);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            cycles(1);
            waited++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected updates never appeared, want 0 pending", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        int lat;
        int want_lat;
        logic [1:0] st0;
        int lv[5];
        int du[5];
        lv = '{1, 0, 1, 0, 1};
        du = '{2, 1, 3, 1, 10};

        rst      = 1'b0;
        sw       = '0;
        selSw    = '0;
        btnEnter = 1'b0;
        btnClear = 1'b0;
        #1 rst = 1'b1;
        cycles(3);
        check_now("reset_values", pack(0, 0, 0, 0, 0));
        rst = 1'b0;
        cycles(3);
        check_now("after_reset_release", pack(0, 0, 0, 0, 0));

        // Entry sequence, with latency measured on the first Enter
        sw = 3'd5;
        cycles(4);
        push("enter_a", 5, 0, 0, 0, 1);
        st0 = state;
        btnEnter = 1'b1;
        lat = 0;
        while (state === st0 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
`ifdef ALU_LOADER_DEBOUNCE_EN
        want_lat = 8;
`else
        want_lat = 4;
`endif
        total++;
        if (lat != want_lat) begin
            bad++;
            $display("FAIL enter_latency: got %0d cycles, want %0d", lat, want_lat);
        end
        cycles(2);
        btnEnter = 1'b0;
        cycles(14);
        drain("enter_a");

        sw = 3'd3;
        cycles(4);
        push("enter_b", 5, 3, 0, 0, 2);
        press(1'b1, 1'b0, 8);
        drain("enter_b");

        selSw = 2'd2;
        cycles(4);
        push("enter_op", 5, 3, 2, 1, 3);
        press(1'b1, 1'b0, 8);
        drain("enter_op");

        push("enter_done", 5, 3, 2, 0, 0);
        press(1'b1, 1'b0, 8);
        drain("enter_done");

        // Second entry, then switch isolation in S_DONE
        sw = 3'd7;
        cycles(4);
        push("enter_a2", 7, 3, 2, 0, 1);
        press(1'b1, 1'b0, 8);
        sw = 3'd0;
        cycles(4);
        push("enter_b2", 7, 0, 2, 0, 2);
        press(1'b1, 1'b0, 8);
        selSw = 2'd1;
        cycles(4);
        push("enter_op2", 7, 0, 1, 1, 3);
        press(1'b1, 1'b0, 8);
        drain("entry2");

        for (int i = 0; i < 50; i++) begin
            sw    = 3'($urandom_range(0, 7));
            selSw = 2'($urandom_range(0, 3));
            cycles(1);
        end
        cycles(6);
        check_now("switch_isolation", pack(7, 0, 1, 1, 3));

        push("clear_from_done", 0, 0, 0, 0, 0);
        press(1'b0, 1'b1, 8);
        drain("clear_from_done");

        // Bouncy Enter in S_A
        sw    = 3'd4;
        selSw = 2'd3;
        cycles(4);
`ifdef ALU_LOADER_DEBOUNCE_EN
        push("bounce_a", 4, 0, 0, 0, 1);
`else
        push("bounce_a", 4, 0, 0, 0, 1);
        push("bounce_b", 4, 4, 0, 0, 2);
        push("bounce_op", 4, 4, 3, 1, 3);
`endif
        for (int i = 0; i < 5; i++) begin
            btnEnter = lv[i][0];
            cycles(du[i]);
        end
        btnEnter = 1'b0;
        cycles(14);
        drain("bounce");
        cycles(20);

        push("clear_after_bounce", 0, 0, 0, 0, 0);
        press(1'b0, 1'b1, 8);
        drain("clear_after_bounce");

        // Held Enter: one capture only
        sw = 3'd6;
        cycles(4);
        push("held_a", 6, 0, 0, 0, 1);
        press(1'b1, 1'b0, 100);
        drain("held_a");
        cycles(10);
        check_now("held_state_b", pack(6, 0, 0, 0, 1));

        // Coincident Enter and Clear in S_B
        sw = 3'd1;
        cycles(4);
        push("clear_priority", 0, 0, 0, 0, 0);
        press(1'b1, 1'b1, 8);
        drain("clear_priority");
        cycles(10);

        // Asynchronous reset mid-entry
        sw = 3'd3;
        cycles(4);
        push("pre_reset_a", 3, 0, 0, 0, 1);
        press(1'b1, 1'b0, 8);
        drain("pre_reset_a");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_now("async_reset", pack(0, 0, 0, 0, 0));
        cycles(2);
        rst = 1'b0;
        cycles(2);

        sw = 3'd5;
        cycles(4);
        push("post_reset_a", 5, 0, 0, 0, 1);
        press(1'b1, 1'b0, 8);
        drain("post_reset_a");
        cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
